// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the convolution datapath: field widths, special
// encodings and the accumulator FSM state type.
package fp16_pkg;

    localparam int unsigned EXP_W   = 5;
    localparam int unsigned MAN_W   = 10;
    localparam int unsigned BIAS    = 15;
    localparam int unsigned EXP_MAX = 31;
    localparam int unsigned FP_W    = 1 + EXP_W + MAN_W;
    // hidden bit + mantissa + guard + round
    localparam int unsigned ALN_W   = MAN_W + 3;
    localparam int unsigned RND_W   = MAN_W + 2;

    localparam logic [FP_W-1:0] FP16_ZERO    = 16'h0000;
    localparam logic [FP_W-1:0] FP16_SAT_POS = 16'h7FFF;
    localparam logic [FP_W-1:0] FP16_SAT_NEG = 16'hFFFF;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp16_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/fp16_add_comb.sv
// Combinational FP16 adder: align, add/subtract, normalise, round-half-up,
// flush-to-zero and saturate. Exponent 0 operands count as zero.
module fp16_add_comb
    import fp16_pkg::*;
(
    input  logic [FP_W-1:0] i_a,
    input  logic [FP_W-1:0] i_b,
    output logic [FP_W-1:0] o_sum
);

    fp16_t             w_a;
    fp16_t             w_b;
    fp16_t             w_big;
    fp16_t             w_small;
    logic              w_a_ge;
    logic [EXP_W-1:0]  w_dexp;
    logic [ALN_W-1:0]  w_mb;
    logic [ALN_W-1:0]  w_ms;
    logic              w_sub;
    logic [ALN_W:0]    w_raw;
    logic [3:0]        w_lz;
    logic [ALN_W-1:0]  w_norm;
    logic signed [6:0] w_exp_norm;
    logic signed [6:0] w_exp_fin;
    logic [RND_W-1:0]  w_rnd;
    logic [MAN_W-1:0]  w_man;
    logic              w_unused;

    // Order operands by magnitude so the subtraction never goes negative
    always_comb begin
        w_a     = i_a;
        w_b     = i_b;
        w_a_ge  = {w_a.exp, w_a.man} >= {w_b.exp, w_b.man};
        w_big   = w_a_ge ? w_a : w_b;
        w_small = w_a_ge ? w_b : w_a;
        w_dexp  = w_big.exp - w_small.exp;
        w_mb    = {1'b1, w_big.man, 2'b00};
        w_ms    = {1'b1, w_small.man, 2'b00} >> w_dexp;
        w_sub   = w_big.sign ^ w_small.sign;
        w_raw   = w_sub ? ({1'b0, w_mb} - {1'b0, w_ms})
                        : ({1'b0, w_mb} + {1'b0, w_ms});
    end

    always_comb begin
        w_lz = '0;
        for (int i = 0; i < ALN_W; i++) begin
            if (w_raw[i]) w_lz = 4'(ALN_W - 1 - i);
        end
    end

    always_comb begin
        w_norm     = w_raw[ALN_W] ? w_raw[ALN_W:1] : (w_raw[ALN_W-1:0] << w_lz);
        w_exp_norm = w_raw[ALN_W] ? (7'(w_big.exp) + 7'sd1) : (7'(w_big.exp) - 7'(w_lz));
        w_rnd      = {1'b0, w_norm[ALN_W-1:2]} + RND_W'(w_norm[1]);
        w_man      = w_rnd[RND_W-1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
        w_exp_fin  = w_exp_norm + 7'(w_rnd[RND_W-1]);
        w_unused   = w_norm[0];

        o_sum = FP16_ZERO;
        if (w_a.exp == '0 && w_b.exp == '0) begin
            o_sum = FP16_ZERO;
        end else if (w_a.exp == '0) begin
            o_sum = w_b;
        end else if (w_b.exp == '0) begin
            o_sum = w_a;
        end else if (w_dexp >= 5'(ALN_W)) begin
            o_sum = w_big;
        end else if (w_raw == '0) begin
            o_sum = FP16_ZERO;
        end else if (w_exp_norm < 7'sd1) begin
            o_sum = FP16_ZERO;
        end else if (w_exp_fin >= $signed(7'(EXP_MAX))) begin
            o_sum = w_big.sign ? FP16_SAT_NEG : FP16_SAT_POS;
        end else begin
            o_sum = {w_big.sign, w_exp_fin[EXP_W-1:0], w_man};
        end
    end

endmodule

// File: rtl/fp16_accum.sv
// Streaming FP16 window accumulator: S1 input register, S2 add + accumulate.
// Optional macro FP16_ACCUM_RELU_EN clamps negative reported sums to +0.
module fp16_accum
    import fp16_pkg::*;
#(
    parameter int unsigned CNT_W = 10
)
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [FP_W-1:0]  data_i,
    input  logic             valid_i,
    input  logic             last_i,
    input  logic             clear_i,
    output logic [FP_W-1:0]  sum_o,
    output logic             sum_valid_o,
    output logic [CNT_W-1:0] term_cnt_o,
    output logic             cnt_ovf_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           r_state;
    state_e           w_state_nxt;
    logic             w_load;

    logic [FP_W-1:0]  r_s1_data;
    logic             r_s1_valid;
    logic             r_s1_last;

    logic [FP_W-1:0]  r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [FP_W-1:0]  r_sum;
    logic             r_sum_valid;
    logic [CNT_W-1:0] r_term_cnt;
    logic             r_ovf;

    logic [FP_W-1:0]  w_op_a;
    logic [FP_W-1:0]  w_sum;
    logic [FP_W-1:0]  w_sum_out;
    logic             w_cnt_sat;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = (r_state == IDLE);
        if (clear_i) begin
            w_state_nxt = IDLE;
        end else if (r_s1_valid) begin
            w_state_nxt = r_s1_last ? IDLE : ACCUM;
        end
    end

    // First term of a window is added to zero, i.e. loaded
    always_comb begin
        w_op_a    = w_load ? FP16_ZERO : r_acc;
        w_cnt_sat = !w_load && (r_cnt == CNT_MAX);
        w_cnt_nxt = w_load ? CNT_W'(1)
                           : (w_cnt_sat ? CNT_MAX : r_cnt + CNT_W'(1));
`ifdef FP16_ACCUM_RELU_EN
        w_sum_out = w_sum[FP_W-1] ? FP16_ZERO : w_sum;
`else
        w_sum_out = w_sum;
`endif
    end

    fp16_add_comb u_add (
        .i_a   (w_op_a),
        .i_b   (r_s1_data),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_s1_data   <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
            r_term_cnt  <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_s1_data   <= data_i;
            r_s1_valid  <= valid_i & ~clear_i;
            r_s1_last   <= last_i;
            r_sum_valid <= 1'b0;
            if (clear_i) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (r_s1_valid) begin
                r_acc <= w_sum;
                r_cnt <= w_cnt_nxt;
                if (w_cnt_sat) r_ovf <= 1'b1;
                if (r_s1_last) begin
                    r_sum       <= w_sum_out;
                    r_sum_valid <= 1'b1;
                    r_term_cnt  <= w_cnt_nxt;
                end
            end
        end
    end

    assign sum_o       = r_sum;
    assign sum_valid_o = r_sum_valid;
    assign term_cnt_o  = r_term_cnt;
    assign cnt_ovf_o   = r_ovf;

endmodule

// File: doc/fp16_accum.md
Name: fp16_accum

Overview:
- Streaming FP16 accumulator placed directly downstream of the FP16 multiplier in the convolution datapath.
- Consumes one product per cycle under a valid/last framing and sums all products of one kernel window.
- Emits one FP16 sum per window and accepts the next window back-to-back with no bubble.
- Number format matches the multiplier: 1 sign, 5 exponent (bias 15), 10 mantissa. No denormals, no Inf/NaN; exponent 31 is the saturated maximum.

Parameters:
- CNT_W, 10, width of the term counter; windows longer than 2^CNT_W-1 terms set the overflow flag.

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- data_i  in  16  FP16 product from the multiplier
- valid_i  in  1  data_i carries a term this cycle
- last_i  in  1  qualifies valid_i; marks the final term of the window
- clear_i  in  1  synchronous abort; discards the window in progress
- sum_o  out  16  FP16 window sum
- sum_valid_o  out  1  one-cycle pulse; sum_o is valid
- term_cnt_o  out  CNT_W  number of terms in the reported window, valid with sum_valid_o
- cnt_ovf_o  out  1  sticky; window exceeded the counter range; cleared by reset or clear_i

Behaviour:
- Reset (asynchronous, rst_n_i low): all registers are 0.
  - sum_o=0, sum_valid_o=0, term_cnt_o=0, cnt_ovf_o=0.
  - State is IDLE.
- Datapath has two stages.
  - S1 registers data_i, valid_i and last_i.
  - S2 adds the S1 term to the accumulator register in one cycle: align, add/subtract, normalise, round, then register.
- Latency: a term with last_i accepted at cycle t gives sum_valid_o=1 at t+2.
- No backpressure; a term is accepted every cycle valid_i=1.
- State machine:
  - IDLE: the first valid term loads the accumulator directly (not added to the old value), counter=1, go to ACCUM.
  - A first term that also has last_i=1 reports immediately and stays in IDLE.
  - ACCUM: each valid term adds, counter+1.
  - A term with last_i=1 completes the window: the result goes to sum_o, sum_valid_o pulses, term_cnt_o is latched, return to IDLE.
  - A valid term in the cycle after last is treated as the first term of a new window (load, not add), so windows run back-to-back.
- valid_i=0 cycles inside a window hold the accumulator and counter unchanged.
- clear_i=1:
  - Drops S1 and S2 contents, goes to IDLE, clears cnt_ovf_o.
  - Does not pulse sum_valid_o.
  - A valid_i term in the same cycle is discarded.
  - sum_o keeps its previous value.
- Addition rules:
  - Exponent difference ≥ 13: the smaller operand is ignored.
  - Alignment uses 13-bit mantissas (hidden bit + 10 + guard + round), round-half-up, matching the multiplier.
  - Exact cancellation gives +0.
  - Exponent < 1 after normalisation flushes to +0.
  - Exponent > 30, or 30 with rounding carry-out, saturates to exp=31, mant=0x3FF with the sign kept.
  - Any input with exp=0 is treated as zero.
- Counter: when it saturates at 2^CNT_W-1 it holds that value and sets cnt_ovf_o; the sum is still reported.
- Simultaneous rst_n_i low and clear_i: reset dominates.

Optional Feature:
- Macro FP16_ACCUM_RELU_EN.
- Defined: a negative completed sum is replaced by +0 in the output register. The sign is seen before registering, so latency is unchanged.
- Undefined: the signed sum is passed through.
- The accumulator itself is never clamped.

Decomposition:
- Shared package fp16_pkg holds:
  - Field widths: EXP_W=5, MAN_W=10, BIAS=15, EXP_MAX=31.
  - Saturation constant 16'h7FFF / 16'hFFFF.
  - Zero constant.
  - The FSM state enum: IDLE, ACCUM.
- One sub-module, fp16_add_comb: purely combinational FP16 add (align, add, normalise, round, saturate) instantiated in S2. It is reusable by the future pooling-average block.

Test Plan:
- Window of three terms 0x3C00, 0x4000, 0x4200 (1+2+3), last on the third → sum_o=0x4600 (6.0), term_cnt_o=3, pulse exactly 2 cycles after the last term.
- Back-to-back windows: {0x3C00, last}, then next cycle {0x4000, 0x4000, last} → two pulses with sums 0x3C00 and 0x4400, no carry-over.
- Cancellation: 0x4500 then 0xC500 (last) → sum_o=0x0000. With FP16_ACCUM_RELU_EN, 0x3C00 then 0xC000 (last) → 0x0000; without it → 0xBC00.
- Saturation: 0x7BFF + 0x7BFF (last) → 0x7FFF; 0xFBFF + 0xFBFF → 0xFFFF.
- clear_i asserted mid-window after two terms, then {0x3C00, last} → single pulse with sum 0x3C00 and term_cnt_o=1.
- Gaps and reset:
  - valid_i=0 bubbles inside a window do not change the sum.
  - Async reset asserted mid-window clears all outputs immediately.
  - The first window after reset is correct.
